// File: rtl/addr_calc_seq.sv
// Sequencer for an external address calculator: loads base/offset over the buses, enables the
// calculator output for OUT_CYCLES cycles, then latches the resulting address from abus.
module addr_calc_seq #(
    parameter int unsigned OUT_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    output logic        o_ready,
    input  logic [15:0] i_base,
    input  logic [7:0]  i_offset,
    input  logic [1:0]  i_mode,
    output logic [15:0] o_abus_drv,
    output logic        o_abus_oe,
    output logic [7:0]  o_mbus_drv,
    output logic        o_mbus_oe,
    output logic        o_ac_loadn,
    output logic        o_ac_outn,
    output logic        o_ac_sign,
    input  logic [15:0] i_abus,
    output logic [15:0] o_result,
    output logic        o_done,
    output logic        o_err
);

    typedef enum logic [1:0] {StIdle, StLoad, StOut, StDone} state_e;

    localparam logic [3:0] LP_CNT_LAST = 4'(OUT_CYCLES - 1);

    state_e      r_state;
    state_e      w_state_next;
    logic [3:0]  r_cnt;
    logic [15:0] r_base;
    logic [7:0]  r_offset;
    logic        r_sign;
    logic [15:0] r_result;
    logic        r_err;
    logic        w_accept;
    logic        w_out_last;

    assign w_accept   = (r_state == StIdle) && i_start;
    assign w_out_last = (r_state == StOut) && (r_cnt == 4'd0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    unique case (i_mode)
                        2'b00:   w_state_next = StDone;
                        2'b01,
                        2'b10:   w_state_next = StLoad;
                        default: w_state_next = StIdle;
                    endcase
                end
            end
            StLoad:  w_state_next = StOut;
            StOut:   w_state_next = w_out_last ? StDone : StOut;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt    <= 4'd0;
            r_base   <= 16'h0000;
            r_offset <= 8'h00;
            r_sign   <= 1'b0;
            r_result <= 16'h0000;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_accept && (i_mode == 2'b11);
            if (w_accept) begin
                r_base   <= i_base;
                r_offset <= i_offset;
                r_sign   <= i_mode[1];
            end
            if (w_accept && (i_mode == 2'b00)) begin
                r_result <= i_base;
            end
            // Counter is armed in LOAD so OUT sees OUT_CYCLES-1 down to 0.
            if (r_state == StLoad) begin
                r_cnt <= LP_CNT_LAST;
            end else if ((r_state == StOut) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_out_last) begin
                r_result <= i_abus;
            end
        end
    end

    always_comb begin
        o_ready    = 1'b0;
        o_abus_oe  = 1'b0;
        o_mbus_oe  = 1'b0;
        o_ac_loadn = 1'b1;
        o_ac_outn  = 1'b1;
        o_ac_sign  = 1'b0;
        o_done     = 1'b0;
        unique case (r_state)
            StIdle: o_ready = 1'b1;
            StLoad: begin
                o_abus_oe  = 1'b1;
                o_mbus_oe  = 1'b1;
                o_ac_loadn = 1'b0;
                o_ac_sign  = r_sign;
            end
            StOut: begin
                o_ac_outn = 1'b0;
                o_ac_sign = r_sign;
            end
            StDone:  o_done = 1'b1;
            default: o_ready = 1'b0;
        endcase
    end

    assign o_abus_drv = r_base;
    assign o_mbus_drv = r_offset;
    assign o_result   = r_result;
    assign o_err      = r_err;

endmodule

// File: doc/addr_calc_seq.md
ADDR_CALC_SEQ -- requirements
Module: addr_calc_seq

Interface
REQ-001 Parameter: OUT_CYCLES, default 1, number of cycles (1..15) the calculator result is driven on abus.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request strobe; accepted only when ready=1.
REQ-005 ready  output  1  high in IDLE; sequencer accepts start.
REQ-006 base  input  16  base address, captured on accept.
REQ-007 offset  input  8  offset, captured on accept.
REQ-008 mode  input  2  00 pass-through, 01 base+unsigned offset, 10 base+signed offset, 11 illegal.
REQ-009 abus_drv  output  16  value driven onto address bus when abus_oe=1.
REQ-010 abus_oe  output  1  enables base drive onto address bus.
REQ-011 mbus_drv  output  8  value driven onto memory bus when mbus_oe=1.
REQ-012 mbus_oe  output  1  enables offset drive onto memory bus.
REQ-013 ac_loadn  output  1  active-low load strobe to address calculator.
REQ-014 ac_outn  output  1  active-low output enable of address calculator.
REQ-015 ac_sign  output  1  calculator offset sign mode.
REQ-016 abus  input  16  address bus as seen by the sequencer, sampled in OUT.
REQ-017 result  output  16  last computed address, held until next completion or reset.
REQ-018 done  output  1  one-cycle completion pulse.
REQ-019 err  output  1  one-cycle pulse on illegal mode request.

Function
REQ-020 States SHALL be IDLE, LOAD, OUT, DONE; encoding is free.
REQ-021 IDLE: ready=1; on edge with start=1, capture base/offset/mode; mode 01/10 -> LOAD, mode 00 -> DONE with result<=base, mode 11 -> stay IDLE, err=1 for the following cycle, result unchanged.
REQ-022 start with ready=0 SHALL be ignored, with no capture and no effect on the active sequence.
REQ-023 LOAD (exactly 1 cycle): abus_oe=1, abus_drv=captured base, mbus_oe=1, mbus_drv=captured offset, ac_loadn=0, ac_sign=captured mode[1]; next state OUT.
REQ-024 OUT (OUT_CYCLES cycles, down-counter): abus_oe=0, mbus_oe=0, ac_loadn=1, ac_outn=0; on the edge ending the final OUT cycle, result<=abus; next state DONE.
REQ-025 DONE (1 cycle): done=1, ready=0, all strobes inactive; next state IDLE.
REQ-026 Latency for modes 01/10: accept edge -> done high 2+OUT_CYCLES cycles later; mode 00: done high in the cycle after accept.
REQ-027 Outside their states, strobes SHALL be inactive: ac_loadn=1, ac_outn=1, abus_oe=0, mbus_oe=0; drv outputs may hold any value.
REQ-028 abus_oe=1 and ac_outn=0 SHALL never coincide (no bus contention); ac_loadn=0 and ac_outn=0 SHALL never coincide.
REQ-029 ac_sign SHALL hold captured mode[1] from LOAD through OUT.
REQ-030 Address arithmetic is performed by the calculator; the sequencer SHALL forward abus unmodified into result (16-bit wrap is the calculator's).
REQ-031 Back-to-back requests: start asserted during DONE is ignored; earliest next accept is the IDLE cycle after DONE.

Reset
REQ-032 reset=1 at an edge SHALL force IDLE from any state, including mid-LOAD/OUT, aborting the sequence without done.
REQ-033 After reset: ready=1, done=0, err=0, result=16'h0000, ac_loadn=1, ac_outn=1, ac_sign=0, abus_oe=0, mbus_oe=0, OUT counter cleared.
REQ-034 reset SHALL take priority over start at the same edge.

Verification
REQ-035 base=64737, offset=168, mode=10, OUT_CYCLES=1, calculator model attached -> LOAD 1 cycle, OUT 1 cycle, done at accept+3, result=64649.
REQ-036 Same operands, mode=01 -> ac_sign=0 throughout, result=64905, done at accept+3.
REQ-037 base=16'hFFFF, offset=1, mode=01 -> result=16'h0000; base=16'h0000, offset=8'hFF, mode=10 -> result=16'hFFFF.
REQ-038 mode=00, base=16'h1234 -> no LOAD/OUT strobes, done at accept+1, result=16'h1234; mode=11 -> err one cycle, ready stays 1, result unchanged.
REQ-039 reset asserted in OUT with OUT_CYCLES=3 -> next cycle IDLE, ac_outn=1, no done, result=0; start asserted while busy -> ignored, captured operands unchanged.
REQ-040 Every cycle of every scenario: assert REQ-028 mutual exclusions and single-cycle done/err.
